shift_serializer: RTL and testbench

Downstream stage of the 16-bit barrel shifter. Takes each parallel shifted word (the shifter's `Op`) through a valid/ready handshake and streams it out LSB-first, one bit per transfer, to the serial adder datapath. A one-entry holding register lets the next word be accepted while the current word is still shifting out. Back-to-back words leave no gap in the stream.

---
 rtl/shift_serializer_if.sv | 31 +++
 rtl/shift_serializer.sv | 115 +++++++++++
 tb/tb_shift_serializer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_serializer_if.sv
// Parallel-in / serial-out handshake bundle between the barrel shifter,
// the serializer and the serial adder datapath.
interface shift_serializer_if #(
  parameter int WIDTH = 16
);
  // Parallel side (barrel shifter -> serializer)
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  // Serial side (serializer -> serial adder)
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_ready;

  // Status
  logic [7:0]       frames_done;

  // Producer/consumer side: drives words and serial backpressure.
  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last, frames_done
  );

  // Serializer side.
  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, frames_done
  );
endinterface

// File: rtl/shift_serializer.sv
// LSB-first serializer with a one-entry holding register. A word waiting in
// the holding register is loaded on the last-bit transfer of the current
// word, so back-to-back words stream with no idle cycle between them.
module shift_serializer #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  shift_serializer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q,      sreg_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       frames_q,    frames_d;

  logic accept;
  logic transfer;
  logic last_bit;

  // Handshake decode. in_ready depends only on registered state and reset.
  assign bus.in_ready = !hold_full_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign transfer     = (state_q == S_SHIFT) && bus.ser_ready;
  assign last_bit     = (cnt_q == CNT_LAST);

  // Serial outputs decoded from registers only; quiet outside SHIFT.
  assign bus.ser_valid   = (state_q == S_SHIFT);
  assign bus.ser_out     = (state_q == S_SHIFT) && sreg_q[0];
  assign bus.ser_last    = (state_q == S_SHIFT) && last_bit;
  assign bus.frames_done = frames_q;

  // Next-state logic: load/shift/drain sequencing and holding-register fill.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    frames_d    = frames_q;

    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          sreg_d      = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (transfer) begin
          if (!last_bit) begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            frames_d = frames_q + 8'd1;
            cnt_d    = '0;
            if (hold_full_q) begin
              // Zero-bubble hand-over to the waiting word.
              sreg_d      = hold_q;
              hold_full_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Accept only when the holding register is empty, so it can never
    // collide with a drain in the same cycle.
    if (accept) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: a scoreboard queue holds the
// expected {bit, last} pairs of each accepted word; a monitor pops and
// compares them on every serial transfer.
module tb_shift_serializer;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0] sb[$];  // {expected ser_out, expected ser_last}

  shift_serializer_if #(.WIDTH(WIDTH)) bus ();

  shift_serializer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: each transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.ser_valid && bus.ser_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_bit: got ser_out=%0b ser_last=%0b, required no transfer",
                 bus.ser_out, bus.ser_last);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if ({bus.ser_out, bus.ser_last} !== e) begin
          tests_failed++;
          $display("FAIL serial_bit: got out=%0b last=%0b, required out=%0b last=%0b",
                   bus.ser_out, bus.ser_last, e[1], e[0]);
        end
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) sb.push_back({w[i], (i == WIDTH - 1)});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ser_ready = 1'b0;
    sb.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Present a word until accepted; returns 1 time unit after the accept edge.
  task automatic send_word(input logic [WIDTH-1:0] w, input int bound);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_word(w);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("FAIL accept_timeout: word %h not accepted in %0d cycles", w, bound);
    end
  endtask

  task automatic wait_drain(input int bound);
    int i;
    i = 0;
    while (sb.size() != 0 && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d bits left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ser_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if ({bus.ser_valid, bus.ser_out, bus.ser_last, bus.in_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid/out/last/in_ready=%b, required 0000",
               {bus.ser_valid, bus.ser_out, bus.ser_last, bus.in_ready});
    end
    tests_run++;
    if (bus.frames_done !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_frames: got %0d, required 0", bus.frames_done);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
    end
    // ser_ready ignored in IDLE: nothing should stream.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_quiet: ser_valid=%b, required 0", bus.ser_valid);
    end
  endtask

  task automatic test_single_word();
    do_reset(2);
    bus.ser_ready = 1'b1;
    send_word(16'h0001, 10);
    tests_run++;
    if (bus.ser_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_e0: valid=%b in_ready=%b, required 0 0", bus.ser_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ser_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_e1: valid=%b in_ready=%b, required 1 1", bus.ser_valid, bus.in_ready);
    end
    wait_drain(40);
    tests_run++;
    if (bus.frames_done !== 8'd1 || bus.ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: frames=%0d valid=%b, required 1 0", bus.frames_done, bus.ser_valid);
    end
  endtask

  task automatic test_back_to_back();
    int  vcnt;
    bit  seen, gap, done, pending;
    do_reset(2);
    bus.ser_ready = 1'b1;
    send_word(16'h8000, 10);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0003;
    pending = 1'b1;
    vcnt = 0; seen = 1'b0; gap = 1'b0; done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (pending && bus.in_ready) begin
        push_word(16'h0003);
        pending = 1'b0;
      end
      if (bus.ser_valid) begin
        vcnt++;
        seen = 1'b1;
      end else if (seen) begin
        if (vcnt < 32) gap = 1'b1;
        else done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!pending) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (vcnt !== 32 || gap) begin
      tests_failed++;
      $display("FAIL b2b_stream: valid cycles=%0d gap=%0b, required 32 0", vcnt, gap);
    end
    tests_run++;
    if (bus.frames_done !== 8'd2) begin
      tests_failed++;
      $display("FAIL b2b_frames: got %0d, required 2", bus.frames_done);
    end
  endtask

  task automatic test_backpressure();
    int   xfers;
    logic stalled;
    logic prev_out, prev_last;
    do_reset(2);
    send_word(16'hA5C3, 10);
    xfers = 0;
    stalled = 1'b0;
    prev_out = 1'b0;
    prev_last = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stalled) begin
        tests_run++;
        if (bus.ser_out !== prev_out || bus.ser_last !== prev_last || bus.ser_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stall_stable: out=%b last=%b valid=%b, required %b %b 1",
                   bus.ser_out, bus.ser_last, bus.ser_valid, prev_out, prev_last);
        end
      end
      stalled   = bus.ser_valid && !bus.ser_ready;
      prev_out  = bus.ser_out;
      prev_last = bus.ser_last;
      if (bus.ser_valid && bus.ser_ready) xfers++;
      @(posedge clk);
      #1;
      bus.ser_ready = ~bus.ser_ready;
    end
    tests_run++;
    if (xfers !== 16 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_transfers: got %0d (left %0d), required 16 (left 0)", xfers, sb.size());
    end
  endtask

  task automatic test_full_hold();
    logic [WIDTH-1:0] words [3];
    int taken;
    words[0] = 16'h1234;
    words[1] = 16'hBEEF;
    words[2] = 16'h0F0F;
    do_reset(2);
    bus.ser_ready = 1'b0;
    taken = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    // Fill sreg and hold with ser_ready low.
    for (int i = 0; i < 10 && taken < 2; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_word(words[taken]);
        taken++;
      end
      @(posedge clk);
      #1;
      bus.in_data = words[taken];
    end
    // Third word must stay pending while nothing drains.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_full_ready: cycle %0d in_ready=%b, required 0", i, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (taken !== 2) begin
      tests_failed++;
      $display("FAIL hold_taken: got %0d, required 2", taken);
    end
    bus.ser_ready = 1'b1;
    for (int i = 0; i < 40 && taken < 3; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_word(words[2]);
        taken++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (taken !== 3) begin
      tests_failed++;
      $display("FAIL third_accept: taken=%0d, required 3", taken);
    end
    wait_drain(80);
    tests_run++;
    if (bus.frames_done !== 8'd3) begin
      tests_failed++;
      $display("FAIL hold_frames: got %0d, required 3", bus.frames_done);
    end
  endtask

  task automatic test_reset_mid_word();
    int i;
    do_reset(2);
    bus.ser_ready = 1'b1;
    send_word(16'hFFFF, 10);
    i = 0;
    while (sb.size() > WIDTH - 7 && i < 40) begin
      @(posedge clk);
      #1;
      i++;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ser_valid !== 1'b0 || bus.frames_done !== 8'd0 || bus.ser_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: valid=%b frames=%0d last=%b, required 0 0 0",
               bus.ser_valid, bus.frames_done, bus.ser_last);
    end
    rst = 1'b0;
    send_word(16'h0002, 10);
    wait_drain(40);
    tests_run++;
    if (bus.frames_done !== 8'd1) begin
      tests_failed++;
      $display("FAIL post_reset_frames: got %0d, required 1", bus.frames_done);
    end
  endtask

  task automatic test_counter_wrap();
    logic [WIDTH-1:0] w;
    do_reset(2);
    bus.ser_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      w = WIDTH'($urandom);
      send_word(w, 40);
      wait_drain(40);
      if (k == 255 || k == 256 || k == 128) begin
        tests_run++;
        if (bus.frames_done !== 8'(k)) begin
          tests_failed++;
          $display("FAIL frames_wrap: after word %0d got %0d, required %0d",
                   k, bus.frames_done, 8'(k));
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ser_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_full_hold();
    test_reset_mid_word();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
